// File: rtl/beat_gate_sequencer.sv
// Beat sequencer for the serial store machine: counts digits within a beat, steps
// SCAN1 -> ACTION -> SCAN2 -> SCAN3 -> SCAN4, and derives the erase/transfer gates.
module beat_gate_sequencer #(
  parameter int LINE_LENGTH         = 40,
  parameter int INSTR_FUNCTION_BITS = 6,
  parameter int DIGIT_BITS          = $clog2(LINE_LENGTH),
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_STA = 6'b010100,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_JMP = 6'b000000,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_NEG = 6'b110110,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SUB = 6'b100110,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_CMP = 6'b000101,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_STP = 6'b000111
) (
  input  logic                           w_CLK,
  input  logic                           w_RST,
  input  logic                           w_RUN,
  input  logic                           w_KSP,
  input  logic [0:INSTR_FUNCTION_BITS-1] b_FST,
  input  logic                           w_A_SIGN,
  input  logic                           w_KLC,
  input  logic                           w_HA,
  output logic [2:0]                     b_BEAT,
  output logic [DIGIT_BITS-1:0]          b_DIGIT,
  output logic                           w_BEAT_END,
  output logic                           w_PARA_ACTION,
  output logic                           w_SE,
  output logic                           w_ACEG,
  output logic                           w_OTG_EN,
  output logic                           w_CI_SKIP,
  output logic                           w_STOPPED
);

  typedef enum logic [2:0] {
    SCAN1  = 3'd0,
    ACTION = 3'd1,
    SCAN2  = 3'd2,
    SCAN3  = 3'd3,
    SCAN4  = 3'd4
  } beat_t;

  localparam logic [DIGIT_BITS-1:0] LAST_DIGIT = DIGIT_BITS'(LINE_LENGTH - 1);

  beat_t                 beat_q, beat_d;
  logic [DIGIT_BITS-1:0] digit_q, digit_d;
  logic                  stopped_q, stopped_d;
  logic                  halt_q, halt_d;
  logic                  skip_q, skip_d;
  logic                  run_q;
  logic                  last_digit;
  logic                  start;

  always_ff @(posedge w_CLK) begin
    if (w_RST) begin
      beat_q    <= SCAN1;
      digit_q   <= '0;
      stopped_q <= 1'b1;
      halt_q    <= 1'b0;
      skip_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      digit_q   <= digit_d;
      stopped_q <= stopped_d;
      halt_q    <= halt_d;
      skip_q    <= skip_d;
      run_q     <= w_RUN;
    end
  end

  // After a halt only a fresh RUN rising edge restarts; a single-shot key always does.
  assign last_digit = (digit_q == LAST_DIGIT);
  assign start      = stopped_q & ((w_RUN & (~halt_q | ~run_q)) | (~w_RUN & w_KSP));

  always_comb begin
    beat_d    = beat_q;
    digit_d   = digit_q;
    stopped_d = stopped_q;
    halt_d    = halt_q;
    skip_d    = skip_q;
    if (stopped_q) begin
      if (start) begin
        stopped_d = 1'b0;
        halt_d    = 1'b0;
      end
    end else if (!last_digit) begin
      digit_d = digit_q + DIGIT_BITS'(1);
    end else begin
      digit_d = '0;
      case (beat_q)
        SCAN1:  beat_d = ACTION;
        ACTION: begin
          beat_d = SCAN2;
          if (b_FST == INST_STP) halt_d = 1'b1;
          if ((b_FST == INST_CMP) && w_A_SIGN) skip_d = 1'b1;
        end
        SCAN2:  beat_d = SCAN3;
        SCAN3:  beat_d = SCAN4;
        default: begin
          beat_d = SCAN1;
          skip_d = 1'b0;
          if (!w_RUN || halt_q) stopped_d = 1'b1;
        end
      endcase
    end
  end

  assign b_BEAT        = beat_q;
  assign b_DIGIT       = digit_q;
  assign w_STOPPED     = stopped_q;
  assign w_BEAT_END    = ~stopped_q & last_digit;
  assign w_PARA_ACTION = ~stopped_q & (beat_q == ACTION);
  // The manual line-clear term bypasses the beat so it works while stopped.
  assign w_SE          = (w_PARA_ACTION & (b_FST == INST_STA)) | (w_KLC & w_HA);
  assign w_ACEG        = w_PARA_ACTION & ((b_FST == INST_JMP) | (b_FST == INST_NEG));
  assign w_OTG_EN      = w_PARA_ACTION &
                         ((b_FST == INST_CMP) | (b_FST == INST_SUB) | (b_FST == INST_NEG));
  assign w_CI_SKIP     = skip_q & (beat_q == SCAN3);

endmodule

// File: doc/beat_gate_sequencer.md
Name: beat_gate_sequencer

Overview:
- Parametrised beat sequencer and data-flow gate generator for the serial store machine.
- Counts digit periods within a beat and steps the beat cycle SCAN1 → ACTION → SCAN2 → SCAN3 → SCAN4.
- Generates the beat-qualified erase and transfer gate waveforms and runs the CMP test/skip logic.
- Sits between the clock/key panel and the SEG/ACEG/OTG gate arrays. It supersedes purely combinational decode with a registered beat and run state.

Parameters:
- LINE_LENGTH, 40: digit periods per beat (≥2).
- INSTR_FUNCTION_BITS, 6: width of b_FST.
- DIGIT_BITS, $clog2(LINE_LENGTH): width of b_DIGIT.
- INST_STA, 6'b010100: store accumulator.
- INST_JMP, 6'b000000: jump (ACEG).
- INST_NEG, 6'b110110: load negative (ACEG, OTG).
- INST_SUB, 6'b100110: subtract (OTG).
- INST_CMP, 6'b000101: test/skip (OTG).
- INST_STP, 6'b000111: stop.

Ports:
- w_CLK, in, 1: digit clock.
- w_RST, in, 1: synchronous active-high reset.
- w_RUN, in, 1: run/stop switch level.
- w_KSP, in, 1: single-shot key, one-cycle pulse.
- b_FST, in, [0:INSTR_FUNCTION_BITS-1]: latched function bits; stable through ACTION.
- w_A_SIGN, in, 1: accumulator serial data digit.
- w_KLC, in, 1: manual line-clear key.
- w_HA, in, 1: manual line address match.
- b_BEAT, out, 3: 0=SCAN1, 1=ACTION, 2=SCAN2, 3=SCAN3, 4=SCAN4.
- b_DIGIT, out, DIGIT_BITS: digit within beat.
- w_BEAT_END, out, 1: high when b_DIGIT==LINE_LENGTH-1 while running.
- w_PARA_ACTION, out, 1: beat==ACTION while running.
- w_SE, out, 1: S erase waveform.
- w_ACEG, out, 1: accumulator erase.
- w_OTG_EN, out, 1: outward transfer enable.
- w_CI_SKIP, out, 1: extra control increment.
- w_STOPPED, out, 1: machine idle.

Behaviour:
- Reset, synchronous: beat=SCAN1, digit=0, stopped=1, halt=0, skip=0, single-shot pending=0. All gate outputs 0 except w_SE, which is the manual term (w_KLC & w_HA).
- Stopped:
  - Digit and beat hold at 0.
  - Start on w_RUN=1 (continuous), or on w_KSP pulse with w_RUN=0 (exactly one instruction).
  - w_KSP while w_RUN=1 is ignored.
  - First running cycle is the cycle after the start condition; digit 0 of SCAN1.
- Running:
  - Digit increments each clock. At LINE_LENGTH-1 the digit wraps to 0 and the beat advances; SCAN4 wraps to SCAN1.
  - One instruction = 5*LINE_LENGTH clocks.
- Stop decision at the last digit of SCAN4: stop if any of
  - w_RUN=0 (including single-shot mode),
  - halt=1.
  Otherwise continue into SCAN1.
- Dropping w_RUN mid-instruction completes through SCAN4.
- halt is set at the last digit of ACTION when b_FST==INST_STP. It is cleared on a start event; a w_RUN rising edge is required to restart after a halt.
- Gates, combinational from registered state:
  - w_SE = (PARA_ACTION & FST==INST_STA) | (w_KLC & w_HA). The manual term works when stopped.
  - w_ACEG = PARA_ACTION & FST∈{JMP,NEG}.
  - w_OTG_EN = PARA_ACTION & FST∈{CMP,SUB,NEG}.
- Skip:
  - At the last digit of ACTION, if FST==INST_CMP and w_A_SIGN=1, set skip.
  - w_CI_SKIP = skip & beat==SCAN3, high for all LINE_LENGTH digits.
  - skip clears at the end of SCAN4 and on reset.
- Reset mid-instruction aborts immediately; no gate output pulses afterwards.

Test Plan:
1. Reset, then w_RUN=1 (default params) → w_STOPPED falls next cycle. w_BEAT_END at digit 39. b_BEAT=1 spans clocks 40–79. Sequence repeats every 200 clocks.
2. w_RUN=0, single w_KSP pulse, FST=INST_STA → exactly 200 running clocks. w_SE high for clocks 40–79 only, then w_STOPPED=1 with b_BEAT=0.
3. FST=INST_CMP, w_A_SIGN=1 at ACTION digit 39 → w_OTG_EN high in ACTION. w_CI_SKIP high for all 40 SCAN3 digits; low in the next instruction when w_A_SIGN=0.
4. FST=INST_STP with w_RUN=1 → stops after SCAN4 of that instruction. Toggling w_RUN 0→1 restarts at SCAN1 digit 0.
5. w_RST during ACTION digit 17 with FST=INST_NEG → next cycle w_ACEG=0, w_OTG_EN=0, b_BEAT=0, b_DIGIT=0, w_STOPPED=1.
6. Stopped with w_KLC=1, w_HA=1 → w_SE=1. Repeat with LINE_LENGTH=4 → beat advances every 4 clocks.
